// File: rtl/multi_port_fifo_if.sv
// Handshake bundle for the N-write/M-read batched FIFO.
// master = producer/consumer side, slave = queue side.
interface multi_port_fifo_if #(
  parameter int NW         = 2,
  parameter int NR         = 2,
  parameter int QLEN       = 8,
  parameter int DATA_WIDTH = 64
);
  localparam int CW = $clog2(QLEN) + 1;

  logic                             flush;
  logic [NW-1:0]                    push_valid;
  logic [NW-1:0][DATA_WIDTH-1:0]    push_data;
  logic                             push_ready;
  logic [NR-1:0]                    pop_valid;
  logic [NR-1:0][DATA_WIDTH-1:0]    pop_data;
  logic [NR-1:0]                    pop_ready;
  logic [CW-1:0]                    count;

  modport master (
    output flush, push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count
  );

  modport slave (
    input  flush, push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count
  );
endinterface

// File: rtl/multi_port_fifo.sv
// Batched NW-push/NR-pop FIFO with lane compaction and prefix pop.
// Optional empty-queue bypass: define MULTI_PORT_FIFO_BYPASS_EN.
module multi_port_fifo #(
  parameter int NW         = 2,
  parameter int NR         = 2,
  parameter int QLEN       = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              resetn,
  multi_port_fifo_if.slave  bus
);
  localparam int AW = $clog2(QLEN);
  localparam int CW = AW + 1;
  localparam int MX = (NW > NR) ? NW : NR;
  localparam logic [CW:0] NW_C = (CW+1)'(NW);
  localparam logic [CW:0] QL_C = (CW+1)'(QLEN);

  typedef logic [DATA_WIDTH-1:0] data_t;

  data_t                         mem [QLEN];
  logic [CW-1:0]                 head, tail, cnt;
  logic                          push_ok, byp;
  logic [CW-1:0]                 acc, k, skip;
  logic [CW-1:0]                 rank [NW];
  data_t                         cdata [MX];
  logic [NR-1:0]                 pv;
  logic [NR-1:0][DATA_WIDTH-1:0] pd;

  // Pointers carry a wrap bit, so the difference is the occupancy.
  assign cnt            = tail - head;
  assign bus.count      = cnt;
  assign bus.push_ready = ({1'b0, cnt} + NW_C) <= QL_C;
  assign push_ok        = bus.push_ready && !bus.flush;
  assign bus.pop_valid  = pv;
  assign bus.pop_data   = pd;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NW; i++) begin
      rank[i] = acc;
      acc     = acc + CW'(bus.push_valid[i]);
    end
    for (int j = 0; j < MX; j++) begin
      cdata[j] = '0;
      for (int i = 0; i < NW; i++) begin
        if (bus.push_valid[i] && rank[i] == CW'(j))
          cdata[j] = bus.push_data[i];
      end
    end
    if (!push_ok)
      acc = '0;
  end

  always_comb begin
    logic run;
    byp = 1'b0;
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    byp = (cnt == '0) && !bus.flush;
`endif
    run = 1'b1;
    k   = '0;
    for (int j = 0; j < NR; j++) begin
      if (byp) begin
        pv[j] = acc > CW'(j);
        pd[j] = cdata[j];
      end else begin
        pv[j] = cnt > CW'(j);
        pd[j] = mem[head[AW-1:0] + AW'(j)];
      end
      if (!pv[j])
        pd[j] = '0;
      run = run & pv[j] & bus.pop_ready[j];
      k   = k + CW'(run);
    end
    // Bypassed lanes consumed this cycle never touch storage.
    skip = byp ? k : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + k - skip;
      tail <= tail + acc - skip;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (CW'(i) < acc && CW'(i) >= skip)
        mem[tail[AW-1:0] + AW'(i) - skip[AW-1:0]] <= cdata[i];
    end
  end
endmodule

// File: tb/tb_multi_port_fifo.sv
// Bench for multi_port_fifo: directed plan steps plus random traffic
// checked against a queue-based reference model.
module tb_multi_port_fifo;
  localparam int QL = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit [7:0] q[$];

  always #5 clk = ~clk;

  multi_port_fifo_if #(
    .NW(2), .NR(2), .QLEN(QL), .DATA_WIDTH(8)
  ) bus ();

  multi_port_fifo #(
    .NW(2), .NR(2), .QLEN(QL), .DATA_WIDTH(8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit fl, bit [1:0] pv, bit [7:0] d0,
                       bit [7:0] d1, bit [1:0] pr);
    bus.flush        = fl;
    bus.push_valid   = pv;
    bus.push_data[0] = d0;
    bus.push_data[1] = d1;
    bus.pop_ready    = pr;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_push_ready"}, 32'(bus.push_ready), 1);
    chk({tag, "_pop_valid"}, 32'(bus.pop_valid), 0);
    chk({tag, "_pop_data"}, 32'(bus.pop_data), 0);
  endtask

  task automatic step(bit fl, bit [1:0] pv, bit [7:0] d0,
                      bit [7:0] d1, bit [1:0] pr);
    bit [7:0] cp[$];
    bit [7:0] off[$];
    bit       byp;
    bit       rdy;
    int       k;
    logic [1:0] ev;
    @(negedge clk);
    drive(fl, pv, d0, d1, pr);
    #1;
    byp = 1'b0;
    rdy = (QL - q.size()) >= 2;
    if (pv[0]) cp.push_back(d0);
    if (pv[1]) cp.push_back(d1);
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    byp = (q.size() == 0) && !fl;
`endif
    if (byp) off = cp;
    else
      for (int j = 0; j < 2; j++)
        if (j < q.size()) off.push_back(q[j]);
    ev = 2'b00;
    for (int j = 0; j < 2; j++) ev[j] = (j < off.size());
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("push_ready", 32'(bus.push_ready), 32'(rdy));
    chk("pop_valid", 32'(bus.pop_valid), 32'(ev));
    for (int j = 0; j < 2; j++)
      chk($sformatf("pop_data%0d", j), 32'(bus.pop_data[j]),
          (j < off.size()) ? 32'(off[j]) : 0);
    if (fl) begin
      q.delete();
    end else begin
      k = 0;
      while (k < off.size() && pr[k]) k++;
      if (!rdy) cp.delete();
      if (byp) begin
        for (int i = k; i < cp.size(); i++) q.push_back(cp[i]);
      end else begin
        repeat (k) void'(q.pop_front());
        foreach (cp[i]) q.push_back(cp[i]);
      end
    end
    @(posedge clk);
  endtask

  task automatic rnd_steps(int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    drive(0, 2'b00, 0, 0, 2'b00);
    #12;
    chk_reset("in_reset");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_reset("idle");

    step(0, 2'b10, 8'hAA, 8'hBB, 2'b00);
    step(0, 2'b00, 8'h00, 8'h00, 2'b00);
    step(1, 2'b00, 8'h00, 8'h00, 2'b00);

    step(0, 2'b11, 8'd1, 8'd2, 2'b00);
    step(0, 2'b11, 8'd3, 8'd4, 2'b00);
    step(0, 2'b11, 8'd5, 8'd6, 2'b00);
    chk("full_count", 32'(bus.count), 4);
    step(0, 2'b00, 8'd0, 8'd0, 2'b10);
    step(0, 2'b00, 8'd0, 8'd0, 2'b11);
    step(0, 2'b00, 8'd0, 8'd0, 2'b01);
    step(0, 2'b11, 8'd7, 8'd8, 2'b01);
    step(0, 2'b01, 8'd11, 8'd0, 2'b00);
    step(0, 2'b00, 8'd0, 8'd0, 2'b00);
    step(1, 2'b11, 8'd12, 8'd13, 2'b00);
    step(0, 2'b11, 8'd9, 8'd10, 2'b01);
    step(0, 2'b00, 8'd0, 8'd0, 2'b11);
    step(0, 2'b00, 8'd0, 8'd0, 2'b00);

    rnd_steps(400);

    step(0, 2'b11, 8'h5A, 8'hA5, 2'b00);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset("mid_reset");
    q.delete();
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 2'b00);
    resetn = 1'b1;
    rnd_steps(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
